// File: rtl/hamming_tx_s.sv
// Serial Hamming(7,4) transmitter: accepts a nibble, builds the receiver-layout
// codeword (optional single-bit flip) and shifts it out MSB-first with a bit strobe.
module hamming_tx_s #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       err_en,
  input  logic [2:0] err_pos,
  output logic       d_out,
  output logic       strobe_out,
  output logic       busy_out,
  output logic       frame_done,
  output logic [6:0] codeword_out
);

  localparam int unsigned PW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CYCLES / 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [PW-1:0] phase;
  logic [GW-1:0] gap_cnt;

  logic [6:0]    cw_clean;
  logic [6:0]    cw_tx;
  logic          ph_wrap;
  logic [PW-1:0] ph_next;
  logic [2:0]    bit_next;

  always_comb begin
    cw_clean = {data_in[3] ^ data_in[2] ^ data_in[0],
                data_in[3] ^ data_in[1] ^ data_in[0],
                data_in[3],
                data_in[2] ^ data_in[1] ^ data_in[0],
                data_in[2],
                data_in[1],
                data_in[0]};
    // err_pos = 7 shifts the single one out of the 7-bit mask: clean codeword.
    cw_tx    = err_en ? (cw_clean ^ (7'b000_0001 << err_pos)) : cw_clean;
  end

  always_comb begin
    ph_wrap  = (phase == PH_LAST);
    ph_next  = ph_wrap ? '0 : phase + PW'(1);
    bit_next = ph_wrap ? bit_idx - 3'd1 : bit_idx;
  end

  // Outputs are driven from the next-cycle phase/bit so they stay registered
  // yet line up with the counters they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_idx      <= '0;
      phase        <= '0;
      gap_cnt      <= '0;
      ready_out    <= 1'b0;
      d_out        <= 1'b0;
      strobe_out   <= 1'b0;
      busy_out     <= 1'b0;
      frame_done   <= 1'b0;
      codeword_out <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_out && valid_in) begin
            codeword_out <= cw_tx;
            d_out        <= cw_tx[6];
            strobe_out   <= 1'b0;
            bit_idx      <= 3'd6;
            phase        <= '0;
            ready_out    <= 1'b0;
            busy_out     <= 1'b1;
            state        <= SHIFT;
          end else begin
            ready_out  <= 1'b1;
            d_out      <= 1'b0;
            strobe_out <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_idx == 3'd0 && ph_wrap) begin
            d_out      <= 1'b0;
            strobe_out <= 1'b0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else begin
            phase      <= ph_next;
            bit_idx    <= bit_next;
            d_out      <= codeword_out[bit_next];
            strobe_out <= (ph_next >= PH_HALF);
            frame_done <= (bit_next == 3'd0) && (ph_next == PH_LAST);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy_out  <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_tx_s.sv
// Scoreboard bench for hamming_tx_s: expected codewords are queued as frames are
// offered and checked against the captured serial stream on frame_done.
module tb_hamming_tx_s;

  localparam int unsigned BC  = 4;
  localparam int unsigned GAP = 2;
  localparam int unsigned LAT_DONE  = 7 * BC;
  localparam int unsigned LAT_READY = 7 * BC + GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       err_en = 1'b0;
  logic [2:0] err_pos = 3'd7;
  logic       d_out;
  logic       strobe_out;
  logic       busy_out;
  logic       frame_done;
  logic [6:0] codeword_out;

  hamming_tx_s #(.BIT_CYCLES(BC), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .err_en       (err_en),
    .err_pos      (err_pos),
    .d_out        (d_out),
    .strobe_out   (strobe_out),
    .busy_out     (busy_out),
    .frame_done   (frame_done),
    .codeword_out (codeword_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [6:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serial monitor: all sampling on the falling edge.
  int unsigned acc_cyc = 0, prev_acc = 0, rdy_cyc = 0, last_st = 0, rx_cnt = 0;
  logic [6:0]  rx_bits = '0;
  logic        prev_strobe = 1'b0, prev_ready = 1'b0, prev_d = 1'b0;
  logic        in_frame = 1'b0, done_seen = 1'b0, had_acc = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0; done_seen = 1'b0; had_acc = 1'b0;
        rx_cnt = 0; prev_strobe = 1'b0; prev_ready = 1'b0; prev_d = 1'b0;
      end else begin
        if (ready_out && !prev_ready && done_seen) begin
          check("ready_latency", cyc - acc_cyc, LAT_READY);
          check("idle_after_gap", {busy_out, strobe_out, d_out}, 3'b000);
          done_seen = 1'b0;
          in_frame  = 1'b0;
          rdy_cyc   = cyc;
        end
        if (done_seen && !ready_out)
          check("gap_outputs", {busy_out, strobe_out, d_out}, 3'b100);
        if (ready_out && valid_in) begin
          if (had_acc && cyc == rdy_cyc)
            check("b2b_spacing", cyc - prev_acc, LAT_READY);
          prev_acc = cyc;
          acc_cyc  = cyc;
          had_acc  = 1'b1;
          in_frame = 1'b1;
          rx_cnt   = 0;
          rx_bits  = '0;
        end else if (in_frame && !done_seen) begin
          if (cyc == acc_cyc + 1) begin
            check("busy_ready_after_acc", {busy_out, ready_out}, 2'b10);
            if (exp_q.size() > 0) check("first_bit", d_out, exp_q[0][6]);
          end
          if (strobe_out && prev_strobe) check("d_stable", d_out, prev_d);
          if (strobe_out && !prev_strobe) begin
            if (rx_cnt == 0) check("first_strobe_lat", cyc - acc_cyc, 1 + BC / 2);
            else             check("strobe_spacing", cyc - last_st, BC);
            last_st = cyc;
            rx_bits = {rx_bits[5:0], d_out};
            rx_cnt++;
          end
          if (frame_done) begin
            check("done_latency", cyc - acc_cyc, LAT_DONE);
            check("strobe_count", rx_cnt, 7);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", exp_q.size(), 1);
            end else begin
              check("serial_stream", rx_bits, exp_q[0]);
              check("codeword_out", codeword_out, exp_q[0]);
              void'(exp_q.pop_front());
            end
            done_seen = 1'b1;
          end
        end
        if (!in_frame && frame_done) check("stray_frame_done", frame_done, 1'b0);
        prev_strobe = strobe_out;
        prev_ready  = ready_out;
        prev_d      = d_out;
      end
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (!ready_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) check("ready_timeout", ready_out, 1'b1);
  endtask

  task automatic send(input logic [3:0] d, input logic en, input logic [2:0] pos,
                      input logic [6:0] exp_cw, input logic hold);
    wait_ready();
    data_in  = d;
    err_en   = en;
    err_pos  = pos;
    valid_in = 1'b1;
    exp_q.push_back(exp_cw);
    @(posedge clk); #1;
    if (!hold) valid_in = 1'b0;
    // Scramble inputs after accept; the in-flight frame must not change.
    data_in = ~d;
    err_en  = ~en;
    err_pos = 3'd0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || !ready_out) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_state", {ready_out, d_out, strobe_out, busy_out, frame_done, codeword_out}, '0);
    idle_cycles(3);
    rst_n = 1'b1;
    check("ready_low_at_release", ready_out, 1'b0);
    @(posedge clk); #1;
    check("ready_after_release", ready_out, 1'b1);

    send(4'b1011, 1'b0, 3'd7, 7'b0110011, 1'b0);
    wait_drain();

    send(4'b0000, 1'b0, 3'd7, 7'b0000000, 1'b1);
    send(4'b1111, 1'b0, 3'd7, 7'b1111111, 1'b0);
    wait_drain();

    send(4'b1011, 1'b1, 3'd2, 7'b0110111, 1'b0);
    wait_drain();

    send(4'b0110, 1'b1, 3'd7, 7'b1100110, 1'b0);
    wait_drain();

    // Reset in the middle of bit h[3]: frame must vanish.
    send(4'b1001, 1'b0, 3'd7, 7'b0011001, 1'b0);
    idle_cycles(3 * BC + 1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("async_reset_outputs",
          {ready_out, d_out, strobe_out, busy_out, frame_done, codeword_out}, '0);
    idle_cycles(2);
    rst_n = 1'b1;
    check("ready_low_after_abort", ready_out, 1'b0);
    @(posedge clk); #1;
    check("ready_after_abort", ready_out, 1'b1);
    send(4'b0001, 1'b0, 3'd7, 7'b1101001, 1'b0);
    wait_drain();

    // valid_in pulsed mid-frame must be ignored.
    send(4'b0110, 1'b0, 3'd7, 7'b1100110, 1'b0);
    idle_cycles(10);
    data_in  = 4'b1111;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_drain();
    idle_cycles(40);
    check("idle_after_ignored", {ready_out, busy_out, strobe_out, d_out}, 4'b1000);
    check("no_extra_frame", exp_q.size(), 0);
    check("codeword_kept", codeword_out, 7'b1100110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
